// File: rtl/fetch_bpu_pkg.sv
// Shared defaults and types for the fetch stage and its branch target buffer.
package fetch_bpu_pkg;

   localparam int          DEF_CNT_W    = 2;
   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic        taken;
      logic [31:0] target;
   } pred_t;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
      return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
   endfunction

endpackage

// File: rtl/fetch_btb.sv
// Direct-mapped branch target buffer: combinational lookup for IF, update from EX.
module fetch_btb
   import fetch_bpu_pkg::*;
#(
   parameter int BTB_ENTRIES = 16,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] lk_pc,
   output pred_t       lk_pred,
   input  logic        up_ctrl,
   input  logic        up_valid,
   input  logic        up_is_jmp,
   input  logic [31:2] up_pc,
   input  logic        up_taken,
   input  logic [31:0] up_target,
   input  logic        up_pred_taken
);

   localparam int IDX_W = $clog2(BTB_ENTRIES);
   localparam int TAG_W = 32 - IDX_W - 2;
   localparam logic [CNT_W-1:0] CNT_WEAK_T = CNT_W'(1) << (CNT_W - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;

   logic             valid_q [BTB_ENTRIES];
   logic             valid_d [BTB_ENTRIES];
   logic [TAG_W-1:0] tag_q   [BTB_ENTRIES];
   logic [TAG_W-1:0] tag_d   [BTB_ENTRIES];
   logic [31:0]      tgt_q   [BTB_ENTRIES];
   logic [31:0]      tgt_d   [BTB_ENTRIES];
   logic [CNT_W-1:0] cnt_q   [BTB_ENTRIES];
   logic [CNT_W-1:0] cnt_d   [BTB_ENTRIES];

   logic [IDX_W-1:0] li;
   logic [IDX_W-1:0] ui;
   logic             lk_hit;
   logic             up_hit;

   always_comb begin
      li             = lk_pc[IDX_W+1:2];
      lk_hit         = valid_q[li] && (tag_q[li] == lk_pc[31:IDX_W+2]);
      lk_pred.taken  = lk_hit && cnt_q[li][CNT_W-1];
      lk_pred.target = lk_hit ? tgt_q[li] : lk_pc + 32'd4;
   end

   // Update decisions use the pre-edge contents, so IF never sees a same-cycle bypass.
   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      tgt_d   = tgt_q;
      cnt_d   = cnt_q;
      ui      = up_pc[IDX_W+1:2];
      up_hit  = valid_q[ui] && (tag_q[ui] == up_pc[31:IDX_W+2]);
      if (up_ctrl) begin
         if (up_hit) begin
            if (up_taken) begin
               tgt_d[ui] = up_target;
               if (cnt_q[ui] != CNT_MAX) cnt_d[ui] = cnt_q[ui] + CNT_W'(1);
            end else if (cnt_q[ui] != '0) begin
               cnt_d[ui] = cnt_q[ui] - CNT_W'(1);
            end
         end else if (up_taken) begin
            valid_d[ui] = 1'b1;
            tag_d[ui]   = up_pc[31:IDX_W+2];
            tgt_d[ui]   = up_target;
            cnt_d[ui]   = up_is_jmp ? CNT_MAX : CNT_WEAK_T;
         end
      end else if (up_valid && up_pred_taken) begin
         valid_d[ui] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '{default: 1'b0};
         tag_q   <= '{default: '0};
         tgt_q   <= '{default: '0};
         cnt_q   <= '{default: '0};
      end else begin
         valid_q <= valid_d;
         tag_q   <= tag_d;
         tgt_q   <= tgt_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/fetch_bpu.sv
// Instruction-fetch stage: PC register, BTB prediction, IF/ID register and EX-driven redirect.
module fetch_bpu
   import fetch_bpu_pkg::*;
#(
   parameter int          IADDR_W     = 14,
   parameter int          BTB_ENTRIES = 16,
   parameter int          CNT_W       = DEF_CNT_W,
   parameter logic [31:0] RESET_PC    = DEF_RESET_PC
) (
   input  logic               cpu_clk,
   input  logic               cpu_rst,
   output logic [IADDR_W-1:0] inst_addr,
   input  logic [31:0]        inst,
   input  logic               pc_stop,
   input  logic               if_id_stop,
   input  logic               ex_valid,
   input  logic               ex_is_br,
   input  logic               ex_is_jmp,
   input  logic [31:0]        ex_pc,
   input  logic               ex_taken,
   input  logic [31:0]        ex_target,
   input  logic               ex_pred_taken,
   input  logic [31:0]        ex_pred_target,
   output logic               id_valid,
   output logic [31:0]        id_pc,
   output logic [31:0]        id_pc4,
   output logic [31:0]        id_inst,
   output logic               id_pred_taken,
   output logic [31:0]        id_pred_target,
   output logic               mispredict,
   output logic [31:0]        br_cnt,
   output logic [31:0]        mis_cnt
);

   logic [31:0] pc_q, pc_d;
   logic        id_valid_q, id_valid_d;
   logic [31:0] id_pc_q, id_pc_d;
   logic [31:0] id_pc4_q, id_pc4_d;
   logic [31:0] id_inst_q, id_inst_d;
   pred_t       id_pred_q, id_pred_d;
   logic [31:0] br_cnt_q, br_cnt_d;
   logic [31:0] mis_cnt_q, mis_cnt_d;

   pred_t       lk_pred;
   logic        ctrl;
   logic [31:0] correct_pc;

   fetch_btb #(
      .BTB_ENTRIES (BTB_ENTRIES),
      .CNT_W       (CNT_W)
   ) u_btb (
      .clk           (cpu_clk),
      .rst           (cpu_rst),
      .lk_pc         (pc_q),
      .lk_pred       (lk_pred),
      .up_ctrl       (ctrl),
      .up_valid      (ex_valid),
      .up_is_jmp     (ex_is_jmp),
      .up_pc         (ex_pc[31:2]),
      .up_taken      (ex_taken),
      .up_target     (ex_target),
      .up_pred_taken (ex_pred_taken)
   );

   always_comb begin
      ctrl       = ex_valid & (ex_is_br | ex_is_jmp);
      // A predicted-taken non-control instruction means the BTB entry aliased.
      mispredict = (ctrl & ((ex_taken != ex_pred_taken) |
                            (ex_taken & (ex_target != ex_pred_target))))
                 | (ex_valid & ~ctrl & ex_pred_taken);
      correct_pc = (ctrl & ex_taken) ? ex_target : ex_pc + 32'd4;

      if (mispredict)         pc_d = correct_pc;
      else if (pc_stop)       pc_d = pc_q;
      else if (lk_pred.taken) pc_d = lk_pred.target;
      else                    pc_d = pc_q + 32'd4;

      id_valid_d = id_valid_q;
      id_pc_d    = id_pc_q;
      id_pc4_d   = id_pc4_q;
      id_inst_d  = id_inst_q;
      id_pred_d  = id_pred_q;
      if (mispredict) begin
         id_valid_d = 1'b0;
         id_pc_d    = '0;
         id_pc4_d   = '0;
         id_inst_d  = '0;
         id_pred_d  = '0;
      end else if (!if_id_stop) begin
         id_valid_d = 1'b1;
         id_pc_d    = pc_q;
         id_pc4_d   = pc_q + 32'd4;
         id_inst_d  = inst;
         id_pred_d  = lk_pred;
      end

      br_cnt_d  = sat_inc32(br_cnt_q, ctrl);
      mis_cnt_d = sat_inc32(mis_cnt_q, mispredict);
   end

   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         pc_q       <= RESET_PC;
         id_valid_q <= 1'b0;
         id_pc_q    <= '0;
         id_pc4_q   <= '0;
         id_inst_q  <= '0;
         id_pred_q  <= '0;
         br_cnt_q   <= '0;
         mis_cnt_q  <= '0;
      end else begin
         pc_q       <= pc_d;
         id_valid_q <= id_valid_d;
         id_pc_q    <= id_pc_d;
         id_pc4_q   <= id_pc4_d;
         id_inst_q  <= id_inst_d;
         id_pred_q  <= id_pred_d;
         br_cnt_q   <= br_cnt_d;
         mis_cnt_q  <= mis_cnt_d;
      end
   end

   assign inst_addr      = pc_q[IADDR_W+1:2];
   assign id_valid       = id_valid_q;
   assign id_pc          = id_pc_q;
   assign id_pc4         = id_pc4_q;
   assign id_inst        = id_inst_q;
   assign id_pred_taken  = id_pred_q.taken;
   assign id_pred_target = id_pred_q.target;
   assign br_cnt         = br_cnt_q;
   assign mis_cnt        = mis_cnt_q;

endmodule
